// File: rtl/cond_pkg.sv
// Shared types and defaults for the input-conditioning blocks
// that feed the enable/clear flop bank.
package cond_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        TRACK = 2'd1,
        EMIT  = 2'd2
    } cond_state_e;

    localparam int unsigned DEF_SYNC_STAGES   = 2;
    localparam int unsigned DEF_STABLE_CYCLES = 16;
    localparam int unsigned DEF_CNT_W         = 8;

endpackage

// File: rtl/sync_chain.sv
// Multi-flop synchroniser for one asynchronous level.
// All stages reset to 0; q is the last stage.
module sync_chain
    import cond_pkg::*;
#(
    parameter int unsigned STAGES = DEF_SYNC_STAGES
) (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] sync_q;
    logic [STAGES-1:0] sync_d;

    always_comb begin
        sync_d = {sync_q[STAGES-2:0], d};
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_q <= '0;
        end else begin
            sync_q <= sync_d;
        end
    end

    assign q = sync_q[STAGES-1];

endmodule

// File: rtl/debounce_sampler.sv
// Synchronise and debounce a raw level; emit a clean bit with a
// one-cycle enable strobe and a registered active-low clear.
module debounce_sampler
    import cond_pkg::*;
#(
    parameter int unsigned SYNC_STAGES   = DEF_SYNC_STAGES,
    parameter int unsigned STABLE_CYCLES = DEF_STABLE_CYCLES,
    parameter int unsigned CNT_W         = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             raw_in,
    input  logic             sample_en,
    input  logic             clr_req,
    output logic             bit_out,
    output logic             bit_valid,
    output logic             clear_n,
    output logic             busy,
    output logic [CNT_W-1:0] stable_cnt
);

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYCLES - 1);

    logic sync;

    cond_state_e      state_q, state_d;
    logic             cand_q, cand_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] cnt_sat;
    logic             bit_out_q, bit_out_d;
    logic             bit_valid_q, bit_valid_d;
    logic             clear_n_q, clear_n_d;

    sync_chain #(
        .STAGES (SYNC_STAGES)
    ) u_sync (
        .clk   (clk),
        .reset (reset),
        .d     (raw_in),
        .q     (sync)
    );

    // Saturating increment: the counter parks at CNT_MAX, never wraps.
    assign cnt_sat = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_W'(1);

    always_comb begin
        state_d     = state_q;
        cand_d      = cand_q;
        cnt_d       = cnt_q;
        bit_out_d   = bit_out_q;
        bit_valid_d = 1'b0;
        clear_n_d   = ~clr_req;

        if (clr_req) begin
            state_d   = IDLE;
            cand_d    = 1'b0;
            cnt_d     = '0;
            bit_out_d = 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    // The entry edge already counts as a tracking sample.
                    if (sample_en) begin
                        state_d = TRACK;
                        if (sync != cand_q) begin
                            cand_d = sync;
                            cnt_d  = '0;
                        end else begin
                            cnt_d = cnt_sat;
                        end
                    end
                end
                TRACK: begin
                    if (!sample_en) begin
                        state_d = IDLE;
                        cnt_d   = '0;
                    end else if (sync != cand_q) begin
                        cand_d = sync;
                        cnt_d  = '0;
                    end else if (cnt_q == CNT_MAX && cand_q != bit_out_q) begin
                        state_d     = EMIT;
                        bit_out_d   = cand_q;
                        bit_valid_d = 1'b1;
                    end else begin
                        cnt_d = cnt_sat;
                    end
                end
                EMIT: begin
                    if (!sample_en) begin
                        state_d = IDLE;
                        cnt_d   = '0;
                    end else begin
                        state_d = TRACK;
                    end
                end
                default: begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            cand_q      <= 1'b0;
            cnt_q       <= '0;
            bit_out_q   <= 1'b0;
            bit_valid_q <= 1'b0;
            clear_n_q   <= 1'b1;
        end else begin
            state_q     <= state_d;
            cand_q      <= cand_d;
            cnt_q       <= cnt_d;
            bit_out_q   <= bit_out_d;
            bit_valid_q <= bit_valid_d;
            clear_n_q   <= clear_n_d;
        end
    end

    assign bit_out    = bit_out_q;
    assign bit_valid  = bit_valid_q;
    assign clear_n    = clear_n_q;
    assign stable_cnt = cnt_q;
    assign busy       = (state_q == TRACK) && (cnt_q != '0);

endmodule

// File: tb/tb_debounce_sampler.sv
// Directed bench for debounce_sampler at SYNC_STAGES=2,
// STABLE_CYCLES=4, with hand-derived per-cycle expectations.
module tb_debounce_sampler;

    localparam int SYNC = 2;
    localparam int STAB = 4;
    localparam int CW   = 8;

    logic          clk = 1'b0;
    logic          reset;
    logic          raw_in;
    logic          sample_en;
    logic          clr_req;
    logic          bit_out;
    logic          bit_valid;
    logic          clear_n;
    logic          busy;
    logic [CW-1:0] stable_cnt;

    int n_vec = 0;
    int n_err = 0;

    int glitch_cnt [10] = '{3, 3, 0, 1, 0, 1, 2, 3, 3, 3};
    int gate_cnt   [6]  = '{0, 1, 2, 3, 3, 3};

    always #5 clk = ~clk;

    debounce_sampler #(
        .SYNC_STAGES   (SYNC),
        .STABLE_CYCLES (STAB),
        .CNT_W         (CW)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .raw_in     (raw_in),
        .sample_en  (sample_en),
        .clr_req    (clr_req),
        .bit_out    (bit_out),
        .bit_valid  (bit_valid),
        .clear_n    (clear_n),
        .busy       (busy),
        .stable_cnt (stable_cnt)
    );

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, want %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset     = 1'b1;
        raw_in    = 1'b0;
        sample_en = 1'b0;
        clr_req   = 1'b0;
        repeat (2) tick();
        reset = 1'b0;
        tick();
    endtask

    task automatic settle();
        sample_en = 1'b1;
        repeat (6) tick();
    endtask

    initial begin
        do_reset();
        chk("rst_out", bit_out, 0);
        chk("rst_valid", bit_valid, 0);
        chk("rst_clr_n", clear_n, 1);
        chk("rst_busy", busy, 0);
        chk("rst_cnt", stable_cnt, 0);

        // basic rise: strobe exactly 6 edges after first sampling edge
        settle();
        raw_in = 1'b1;
        for (int k = 0; k < 10; k++) begin
            tick();
            chk("rise_valid", bit_valid, 32'(k == 6));
            chk("rise_out", bit_out, 32'(k >= 6));
            chk("rise_clr_n", clear_n, 1);
        end

        // async reset mid-count with bit_out=1
        raw_in = 1'b0;
        repeat (5) tick();
        chk("mid_cnt", stable_cnt, 2);
        chk("mid_busy", busy, 1);
        chk("mid_out_pre", bit_out, 1);
        #2 reset = 1'b1;
        #1;
        chk("arst_out", bit_out, 0);
        chk("arst_cnt", stable_cnt, 0);
        chk("arst_busy", busy, 0);
        chk("arst_valid", bit_valid, 0);
        chk("arst_clr_n", clear_n, 1);
        tick();
        reset = 1'b0;
        for (int k = 0; k < 10; k++) begin
            tick();
            chk("arst_post_valid", bit_valid, 0);
            chk("arst_post_out", bit_out, 0);
        end

        // glitch rejection: two high samples only
        do_reset();
        settle();
        raw_in = 1'b1;
        for (int k = 0; k < 10; k++) begin
            tick();
            if (k == 1) raw_in = 1'b0;
            chk("glitch_valid", bit_valid, 0);
            chk("glitch_out", bit_out, 0);
            chk("glitch_cnt", stable_cnt, glitch_cnt[k]);
        end

        // clear has priority over the pending emission
        do_reset();
        settle();
        raw_in = 1'b1;
        for (int k = 0; k < 8; k++) begin
            tick();
            if (k == 5) clr_req = 1'b1;
            chk("clr_valid", bit_valid, 0);
            chk("clr_out", bit_out, 0);
            chk("clr_clr_n", clear_n, 32'(k != 6));
            if (k == 6) begin
                chk("clr_busy", busy, 0);
                chk("clr_cnt", stable_cnt, 0);
                clr_req = 1'b0;
                raw_in  = 1'b0;
            end
        end

        // sample_en gating, then strobe 4 edges after enabling
        do_reset();
        for (int k = 0; k < 26; k++) begin
            raw_in = (k < 6) ? 1'(k & 1) : 1'b1;
            tick();
            chk("gate_valid", bit_valid, 0);
            chk("gate_cnt", stable_cnt, 0);
        end
        sample_en = 1'b1;
        for (int k = 0; k < 6; k++) begin
            tick();
            chk("gate_en_valid", bit_valid, 32'(k == 4));
            chk("gate_en_out", bit_out, 32'(k >= 4));
            chk("gate_en_cnt", stable_cnt, gate_cnt[k]);
        end

        // fall path
        raw_in = 1'b0;
        for (int k = 0; k < 10; k++) begin
            tick();
            chk("fall_valid", bit_valid, 32'(k == 6));
            chk("fall_out", bit_out, 32'(k < 6));
        end

        // short noise returning to the accepted level
        for (int k = 0; k < 12; k++) begin
            raw_in = (k < 3) ? 1'b1 : 1'b0;
            tick();
            chk("noise_valid", bit_valid, 0);
            chk("noise_out", bit_out, 0);
        end
        chk("noise_cnt", stable_cnt, 3);
        chk("noise_busy", busy, 1);

        // sample_en drops during EMIT: strobe still delivered
        do_reset();
        settle();
        raw_in = 1'b1;
        for (int k = 0; k < 9; k++) begin
            tick();
            chk("emit_en_valid", bit_valid, 32'(k == 6));
            if (k == 6) sample_en = 1'b0;
            if (k == 7) begin
                chk("emit_en_cnt", stable_cnt, 0);
                chk("emit_en_busy", busy, 0);
                chk("emit_en_out", bit_out, 1);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
